pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Fetch-stage PC sequencer for the pipelined MIPS core. It owns the PC register and computes branch targets (sign-extended 16-bit offset shifted left 2, added to PC+4) and jump targets (26-bit field shifted left 2, concatenated with PC+4[31:28]). It arbitrates between sequential fetch, hazard stalls, ID-stage branch/jump redirects and instruction-memory wait states, and drives the IF/ID register write-enable and flush.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMM_W, 16, branch offset width
- JADDR_W, 26, jump address field width
- SHIFT, 2, word-to-byte shift applied to offsets and jump field
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_id  in  1  load-use hazard; freeze PC and IF/ID
- branch_taken  in  1  branch in ID resolved taken
- branch_imm  in  IMM_W  branch offset of ID instruction (words, signed)
- jump  in  1  ID instruction is J/JAL
- jump_addr  in  JADDR_W  jump target field
- id_pc_plus4  in  32  PC+4 of the ID instruction
- imem_ready  in  1  fetch at pc_out completes this cycle
- pc_out  out  32  fetch address, registered
- if_pc_plus4  out  32  pc_out + 4, modulo 2^32
- if_id_write  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID loads a bubble (NOP)
- redirect_pending  out  1  high in state PEND

## Operation
- Branch target: id_pc_plus4 + (sign_extend(branch_imm) << SHIFT), 32-bit, wraps modulo 2^32.
- Jump target: {id_pc_plus4[31:28], jump_addr, 2'b00}.
- redirect_req = !stall_id && (jump || branch_taken); target = jump ? jump target : branch target (jump wins if both).
- States: RUN, PEND. pending_target register (32 bits).
- RUN, priority high to low:
  - stall_id=1: PC holds; if_id_write=0, if_id_flush=0; branch/jump/imem_ready ignored.
  - redirect_req, imem_ready=1: pc_out <= target; if_id_write=1, if_id_flush=1; stay RUN.
  - redirect_req, imem_ready=0: PC holds (memory keeps address until done); pending_target <= target; if_id_write=1, if_id_flush=1; go PEND.
  - imem_ready=0: PC holds; if_id_write=1, if_id_flush=1 (bubble into ID).
  - otherwise: pc_out <= pc_out + 4; if_id_write=1, if_id_flush=0.
- PEND: stall_id, branch_taken, jump ignored (ID holds a bubble). if_id_write=1, if_id_flush=1 every cycle. When imem_ready=1: pc_out <= pending_target, go RUN. Otherwise remain.
- Reset (rst_n=0, asynchronous): pc_out=RESET_PC, if_pc_plus4=RESET_PC+4, state RUN, pending_target=0, redirect_pending=0; if_id_write=1, if_id_flush=1 forced while rst_n low.
- Reset asserted in PEND discards pending_target; first fetch after release is RESET_PC.

## Timing
- pc_out, pending_target, state: registered on clk rising edge; if_pc_plus4 combinational from pc_out.
- if_id_write, if_id_flush, redirect_pending: combinational from state and current-cycle inputs; no registered latency.
- Redirect penalty: one bubble when imem_ready=1 at redirect cycle; 1 + N bubbles when the wrong-path fetch needs N further wait cycles.
- Target appears on pc_out the cycle after redirect (RUN) or the cycle after imem_ready rises (PEND).
- First edge after rst_n release with imem_ready=1: pc_out RESET_PC -> RESET_PC+4.

## Test plan
- Reset then imem_ready=1, no hazards, 4 cycles -> pc_out 0x0, 0x4, 0x8, 0xC, 0x10; if_id_flush=0 after reset release.
- id_pc_plus4=0x0000_0040, branch_imm=0xFFFE, branch_taken=1, imem_ready=1 -> if_id_flush=1 that cycle, pc_out=0x0000_0038 next cycle; wrap check: id_pc_plus4=0xFFFF_FFFC, imm=0x0001 -> pc_out=0x0000_0000.
- id_pc_plus4=0x9000_0010, jump_addr=0x000_0100, jump=1 and branch_taken=1 same cycle -> pc_out=0x9000_0400 (jump wins).
- stall_id=1 with branch_taken=1 and imem_ready=0 for 2 cycles -> pc_out unchanged, if_id_write=0, if_id_flush=0; redirect taken only on cycle stall drops.
- Branch to 0x0000_0100 with imem_ready=0 for 3 cycles -> redirect_pending=1 for 3 cycles, if_id_flush=1 throughout, pc_out held; imem_ready=1 -> pc_out=0x0000_0100 next cycle, back to RUN.
- rst_n pulsed low mid-PEND -> pc_out=RESET_PC immediately, redirect_pending=0, pending target never fetched.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_redirect_ctrl
//  Description : Fetch-stage PC sequencer. Owns the PC register, computes
//                branch and jump targets from the ID-stage instruction, and
//                arbitrates between sequential fetch, load-use stalls,
//                ID-stage redirects and instruction-memory wait states.
//                Drives the IF/ID load enable and bubble-insert flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMM_W    = 16,
    parameter int          JADDR_W  = 26,
    parameter int          SHIFT    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_id,
    input  logic               branch_taken,
    input  logic [IMM_W-1:0]   branch_imm,
    input  logic               jump,
    input  logic [JADDR_W-1:0] jump_addr,
    input  logic [31:0]        id_pc_plus4,
    input  logic               imem_ready,
    output logic [31:0]        pc_out,
    output logic [31:0]        if_pc_plus4,
    output logic               if_id_write,
    output logic               if_id_flush,
    output logic               redirect_pending
);

    // RUN: normal sequencing. PEND: a redirect was accepted while the
    // wrong-path fetch was still outstanding; wait for it to retire.
    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic [31:0] w_imm_sext;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_target;
    logic        w_redirect_req;

    // Target computation: the jump field replaces the low 28 bits of PC+4,
    // the branch offset is a signed word count added to PC+4.
    assign w_imm_sext     = {{(32-IMM_W){branch_imm[IMM_W-1]}}, branch_imm};
    assign w_branch_tgt   = id_pc_plus4 + (w_imm_sext << SHIFT);
    assign w_jump_tgt     = {id_pc_plus4[31:28], jump_addr, {SHIFT{1'b0}}};
    assign w_redirect_req = !stall_id && (jump || branch_taken);
    assign w_target       = jump ? w_jump_tgt : w_branch_tgt;

    assign pc_out           = pc_q;
    assign if_pc_plus4      = pc_q + 32'd4;
    assign redirect_pending = (state_q == S_PEND);

    // IF/ID control is combinational so a redirect squashes the wrong-path
    // fetch in the same cycle it is resolved.
    always_comb begin
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        if (!rst_n) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
        end else if (state_q == S_PEND) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
        end else if (stall_id) begin
            if_id_write = 1'b0;
            if_id_flush = 1'b0;
        end else if (w_redirect_req || !imem_ready) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
        end else begin
            if_id_write = 1'b1;
            if_id_flush = 1'b0;
        end
    end

    // Next-state selection for PC, pending target and FSM state.
    // The PC must not move while a fetch is outstanding, so a redirect that
    // arrives during a memory wait is parked in pend_tgt until it completes.
    always_comb begin
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        state_d    = state_q;
        case (state_q)
            S_RUN: begin
                if (stall_id) begin
                    pc_d = pc_q;
                end else if (w_redirect_req && imem_ready) begin
                    pc_d = w_target;
                end else if (w_redirect_req) begin
                    pend_tgt_d = w_target;
                    state_d    = S_PEND;
                end else if (imem_ready) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            S_PEND: begin
                if (imem_ready) begin
                    pc_d    = pend_tgt_q;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State registers; asynchronous reset discards any parked redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            pend_tgt_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_redirect_ctrl
//  Description : Directed-vector testbench for pc_redirect_ctrl. Each vector
//                carries hand-computed expected outputs for the cycle in
//                which it is applied; a monitor compares them mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall_id;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_addr;
    logic [31:0] id_pc_plus4;
    logic        imem_ready;
    logic [31:0] pc_out;
    logic [31:0] if_pc_plus4;
    logic        if_id_write;
    logic        if_id_flush;
    logic        redirect_pending;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        wr;
        logic        fl;
        logic        pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    pc_redirect_ctrl #(
        .RESET_PC (32'h0000_0000),
        .IMM_W    (16),
        .JADDR_W  (26),
        .SHIFT    (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_id         (stall_id),
        .branch_taken     (branch_taken),
        .branch_imm       (branch_imm),
        .jump             (jump),
        .jump_addr        (jump_addr),
        .id_pc_plus4      (id_pc_plus4),
        .imem_ready       (imem_ready),
        .pc_out           (pc_out),
        .if_pc_plus4      (if_pc_plus4),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check32({e.name, ".pc_out"},      pc_out,           e.pc);
                check32({e.name, ".if_pc_plus4"}, if_pc_plus4,      e.pc + 32'd4);
                check1 ({e.name, ".if_id_write"}, if_id_write,      e.wr);
                check1 ({e.name, ".if_id_flush"}, if_id_flush,      e.fl);
                check1 ({e.name, ".pending"},     redirect_pending, e.pend);
            end
        end
    end

    // Apply one cycle of stimulus just after the rising edge and queue the
    // outputs expected for that cycle.
    task automatic vec(input string nm, input logic rst, input logic stl,
                       input logic br, input logic [15:0] imm, input logic jmp,
                       input logic [25:0] ja, input logic [31:0] pc4,
                       input logic rdy, input logic [31:0] e_pc,
                       input logic e_wr, input logic e_fl, input logic e_pend);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst;
        stall_id     = stl;
        branch_taken = br;
        branch_imm   = imm;
        jump         = jmp;
        jump_addr    = ja;
        id_pc_plus4  = pc4;
        imem_ready   = rdy;
        e.name = nm; e.pc = e_pc; e.wr = e_wr; e.fl = e_fl; e.pend = e_pend;
        exp_q.push_back(e);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        stall_id     = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = 16'h0;
        jump         = 1'b0;
        jump_addr    = 26'h0;
        id_pc_plus4  = 32'h0;
        imem_ready   = 1'b1;

        //   name         rst stl br imm      jmp ja        pc4           rdy  e_pc          wr fl pend
        vec("reset",      0,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h0,        1, 1, 0);
        vec("seq0",       1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h0,        1, 0, 0);
        vec("seq4",       1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h4,        1, 0, 0);
        vec("seq8",       1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h8,        1, 0, 0);
        vec("seqC",       1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'hC,        1, 0, 0);
        // backward branch: 0x40 + (-2 << 2) = 0x38
        vec("br_back",    1,  0,  1, 16'hFFFE,0,  26'h0,    32'h40,       1,   32'h10,       1, 1, 0);
        // wrap: 0xFFFFFFFC + 4 = 0
        vec("br_wrap",    1,  0,  1, 16'h0001,0,  26'h0,    32'hFFFF_FFFC,1,   32'h38,       1, 1, 0);
        // jump wins over branch: {9, 0x100, 00} = 0x90000400
        vec("jmp_win",    1,  0,  1, 16'h0005,1,  26'h100,  32'h9000_0010,1,   32'h0,        1, 1, 0);
        // stall masks the branch and memory wait
        vec("stall1",     1,  1,  1, 16'h0010,0,  26'h0,    32'h200,      0,   32'h9000_0400,0, 0, 0);
        vec("stall2",     1,  1,  1, 16'h0010,0,  26'h0,    32'h200,      0,   32'h9000_0400,0, 0, 0);
        // stall drops: 0x200 + (0x10 << 2) = 0x240
        vec("stall_rel",  1,  0,  1, 16'h0010,0,  26'h0,    32'h200,      1,   32'h9000_0400,1, 1, 0);
        vec("after_br",   1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h240,      1, 0, 0);
        vec("imem_wait",  1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        0,   32'h244,      1, 1, 0);
        // redirect during wait: 0xFC + 4 = 0x100 is parked
        vec("br_park",    1,  0,  1, 16'h0001,0,  26'h0,    32'h0FC,      0,   32'h244,      1, 1, 0);
        vec("pend1",      1,  1,  1, 16'h0100,0,  26'h0,    32'h1000,     0,   32'h244,      1, 1, 1);
        vec("pend2",      1,  0,  0, 16'h0,   1,  26'h3FF,  32'h2000,     0,   32'h244,      1, 1, 1);
        vec("pend3",      1,  0,  1, 16'h0020,0,  26'h0,    32'h3000,     0,   32'h244,      1, 1, 1);
        vec("pend_done",  1,  0,  1, 16'h0020,1,  26'h55,   32'h3000,     1,   32'h244,      1, 1, 1);
        vec("pend_tgt",   1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h100,      1, 0, 0);
        vec("seq104",     1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h104,      1, 0, 0);
        // park 0x500, then reset in PEND
        vec("br_park2",   1,  0,  1, 16'h0001,0,  26'h0,    32'h4FC,      0,   32'h108,      1, 1, 0);
        vec("pend_b",     1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        0,   32'h108,      1, 1, 1);
        vec("rst_pend",   0,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h0,        1, 1, 0);
        vec("rst_hold",   0,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h0,        1, 1, 0);
        vec("rst_rel",    1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h0,        1, 0, 0);
        vec("rst_seq4",   1,  0,  0, 16'h0,   0,  26'h0,    32'h0,        1,   32'h4,        1, 0, 0);

        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
